// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: word-addressed instruction memory behind a fixed-latency
// read pipeline and an in-order valid/ready response FIFO, with flush and a load port.
module imem_fetch_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [31:0]   req_addr_i,
  input  logic          flush_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [31:0]   rsp_addr_o,
  output logic [31:0]   rsp_instr_o,
  output logic          rsp_fault_o,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_data_i
);

  localparam int NS = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and req_ready depends only on registered credits and flush.

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (load_we_i) mem[load_addr_i] <= load_data_i;
  end

  logic        accept;
  logic [31:0] word_idx;
  logic        in_fault;
  logic [31:0] in_instr;

  assign accept   = req_valid_i & req_ready_o;
  assign word_idx = {2'b00, req_addr_i[31:2]};
  assign in_fault = (req_addr_i[1:0] != 2'b00) || (word_idx >= 32'(DEPTH_WORDS));
  // Memory is read in the accept cycle, so a same-cycle load write is not yet visible.
  assign in_instr = in_fault ? NOP : mem[req_addr_i[AW+1:2]];

  logic        st_v     [NS];
  logic [31:0] st_addr  [NS];
  logic [31:0] st_instr [NS];
  logic        st_fault [NS];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NS; i++) st_v[i] <= 1'b0;
    end else begin
      // A request accepted alongside flush belongs to the new stream and survives.
      st_v[0] <= accept;
      for (int i = 1; i < NS; i++) st_v[i] <= st_v[i-1] & ~flush_i;
    end
  end

  always_ff @(posedge clk_i) begin
    st_addr[0]  <= req_addr_i;
    st_instr[0] <= in_instr;
    st_fault[0] <= in_fault;
    for (int i = 1; i < NS; i++) begin
      st_addr[i]  <= st_addr[i-1];
      st_instr[i] <= st_instr[i-1];
      st_fault[i] <= st_fault[i-1];
    end
  end

  logic        push_v;
  logic [31:0] push_addr;
  logic [31:0] push_instr;
  logic        push_fault;

  assign push_v     = (LATENCY == 1) ? accept : (st_v[NS-1] & ~flush_i);
  assign push_addr  = (LATENCY == 1) ? req_addr_i : st_addr[NS-1];
  assign push_instr = (LATENCY == 1) ? in_instr : st_instr[NS-1];
  assign push_fault = (LATENCY == 1) ? in_fault : st_fault[NS-1];

  logic [31:0] f_addr  [FIFO_DEPTH];
  logic [31:0] f_instr [FIFO_DEPTH];
  logic        f_fault [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr, wr_idx;
  logic [CW-1:0] count, inflight;
  logic [CW:0]   credits_used;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop    = rsp_valid_o & rsp_ready_i;
  assign wr_idx = flush_i ? '0 : wptr;

  always_ff @(posedge clk_i) begin
    if (push_v) begin
      f_addr[wr_idx]  <= push_addr;
      f_instr[wr_idx] <= push_instr;
      f_fault[wr_idx] <= push_fault;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      inflight <= '0;
    end else if (flush_i) begin
      rptr     <= '0;
      wptr     <= push_v ? ptr_inc('0) : '0;
      count    <= CW'(push_v);
      inflight <= CW'(accept && (LATENCY > 1));
    end else begin
      if (push_v) wptr <= ptr_inc(wptr);
      if (pop)    rptr <= ptr_inc(rptr);
      count    <= count + CW'(push_v) - CW'(pop);
      inflight <= inflight + CW'(accept) - CW'(push_v);
    end
  end

  assign credits_used = {1'b0, inflight} + {1'b0, count};
  assign req_ready_o  = flush_i | (credits_used < (CW+1)'(FIFO_DEPTH));

  assign rsp_valid_o = (count != '0);
  assign rsp_addr_o  = rsp_valid_o ? f_addr[rptr]  : 32'h0;
  assign rsp_instr_o = rsp_valid_o ? f_instr[rptr] : 32'h0;
  assign rsp_fault_o = rsp_valid_o ? f_fault[rptr] : 1'b0;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: cycle-by-cycle vector table plus directed sequences
// for backpressure, flush and mid-operation reset.
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_addr_o;
  logic [31:0] rsp_instr_o;
  logic        rsp_fault_o;
  logic        load_we_i = 1'b0;
  logic [9:0]  load_addr_i = '0;
  logic [31:0] load_data_i = '0;

  imem_fetch_responder dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .flush_i(flush_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_addr_o(rsp_addr_o), .rsp_instr_o(rsp_instr_o), .rsp_fault_o(rsp_fault_o),
    .load_we_i(load_we_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [int];

  typedef struct {
    string       name;
    logic        rv;
    logic [31:0] ra;
    logic        rr;
    logic        we;
    logic [9:0]  la;
    logic [31:0] ld;
    logic        e_rdy;
    logic        e_v;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic        e_f;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input string n, input logic rv, input logic [31:0] ra,
                              input logic rr, input logic we, input logic [9:0] la,
                              input logic [31:0] ld, input logic erdy, input logic ev,
                              input logic [31:0] ea, input logic [31:0] ei, input logic ef);
    vec_t v;
    v.name = n; v.rv = rv; v.ra = ra; v.rr = rr; v.we = we; v.la = la; v.ld = ld;
    v.e_rdy = erdy; v.e_v = ev; v.e_addr = ea; v.e_instr = ei; v.e_f = ef;
    vecs.push_back(v);
  endfunction

  // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
  task automatic step(input logic rv, input logic [31:0] ra, input logic rr,
                      input logic fl, input logic rst);
    @(negedge clk);
    reset_i = rst; req_valid_i = rv; req_addr_i = ra; rsp_ready_i = rr; flush_i = fl;
    load_we_i = 1'b0;
    #1;
  endtask

  task automatic do_load(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    reset_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0; flush_i = 1'b0;
    load_we_i = 1'b1; load_addr_i = idx; load_data_i = data;
    model_mem[int'(idx)] = data;
  endtask

  task automatic apply_row(input vec_t v);
    @(negedge clk);
    reset_i = 1'b0; flush_i = 1'b0;
    req_valid_i = v.rv; req_addr_i = v.ra; rsp_ready_i = v.rr;
    load_we_i = v.we; load_addr_i = v.la; load_data_i = v.ld;
    #1;
    chk({v.name, ".req_ready"}, 32'(req_ready_o), 32'(v.e_rdy));
    chk({v.name, ".rsp_valid"}, 32'(rsp_valid_o), 32'(v.e_v));
    chk({v.name, ".rsp_addr"}, rsp_addr_o, v.e_addr);
    chk({v.name, ".rsp_instr"}, rsp_instr_o, v.e_instr);
    chk({v.name, ".rsp_fault"}, 32'(rsp_fault_o), 32'(v.e_f));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int next;
    int got;
    int seen;
    logic [31:0] a;
    logic [31:0] e;

    // name, rv, ra, rr, we, la, ld | rdy, v, addr, instr, fault
    add("idle_after_reset",   0, 32'h0,    0, 0, 10'd0,    32'h0,         1, 0, 32'h0,    32'h0,         0);
    add("load_w0",            0, 32'h0,    0, 1, 10'd0,    32'h0000_0093, 1, 0, 32'h0,    32'h0,         0);
    add("load_w1",            0, 32'h0,    0, 1, 10'd1,    32'h0010_0113, 1, 0, 32'h0,    32'h0,         0);
    add("req_0",              1, 32'h0,    1, 0, 10'd0,    32'h0,         1, 0, 32'h0,    32'h0,         0);
    add("req_4",              1, 32'h4,    1, 0, 10'd0,    32'h0,         1, 0, 32'h0,    32'h0,         0);
    add("rsp_0",              0, 32'h0,    1, 0, 10'd0,    32'h0,         1, 1, 32'h0,    32'h0000_0093, 0);
    add("rsp_4",              0, 32'h0,    1, 0, 10'd0,    32'h0,         1, 1, 32'h4,    32'h0010_0113, 0);
    add("drained",            0, 32'h0,    1, 0, 10'd0,    32'h0,         1, 0, 32'h0,    32'h0,         0);
    add("req_misaligned",     1, 32'h2,    1, 0, 10'd0,    32'h0,         1, 0, 32'h0,    32'h0,         0);
    add("req_oor",            1, 32'h1000, 1, 0, 10'd0,    32'h0,         1, 0, 32'h0,    32'h0,         0);
    add("rsp_misaligned",     0, 32'h0,    1, 0, 10'd0,    32'h0,         1, 1, 32'h2,    32'h0000_0013, 1);
    add("rsp_oor",            0, 32'h0,    1, 0, 10'd0,    32'h0,         1, 1, 32'h1000, 32'h0000_0013, 1);
    add("load_w1023",         0, 32'h0,    0, 1, 10'd1023, 32'hCAFE_F00D, 1, 0, 32'h0,    32'h0,         0);
    add("req_last_word",      1, 32'hFFC,  1, 0, 10'd0,    32'h0,         1, 0, 32'h0,    32'h0,         0);
    add("wait_last_word",     0, 32'h0,    1, 0, 10'd0,    32'h0,         1, 0, 32'h0,    32'h0,         0);
    add("rsp_last_word",      0, 32'h0,    1, 0, 10'd0,    32'h0,         1, 1, 32'hFFC,  32'hCAFE_F00D, 0);
    add("load_w5_zero",       0, 32'h0,    0, 1, 10'd5,    32'h0,         1, 0, 32'h0,    32'h0,         0);
    add("req_w5_during_write",1, 32'h14,   1, 1, 10'd5,    32'hDEAD_BEEF, 1, 0, 32'h0,    32'h0,         0);
    add("req_w5_after_write", 1, 32'h14,   1, 0, 10'd0,    32'h0,         1, 0, 32'h0,    32'h0,         0);
    add("rsp_w5_old",         0, 32'h0,    1, 0, 10'd0,    32'h0,         1, 1, 32'h14,   32'h0,         0);
    add("rsp_w5_new",         0, 32'h0,    1, 0, 10'd0,    32'h0,         1, 1, 32'h14,   32'hDEAD_BEEF, 0);
    add("req_hold",           1, 32'h0,    0, 0, 10'd0,    32'h0,         1, 0, 32'h0,    32'h0,         0);
    add("wait_hold",          0, 32'h0,    0, 0, 10'd0,    32'h0,         1, 0, 32'h0,    32'h0,         0);
    add("hold_a",             0, 32'h0,    0, 0, 10'd0,    32'h0,         1, 1, 32'h0,    32'h0000_0093, 0);
    add("hold_b",             0, 32'h0,    0, 0, 10'd0,    32'h0,         1, 1, 32'h0,    32'h0000_0093, 0);
    add("hold_pop",           0, 32'h0,    1, 0, 10'd0,    32'h0,         1, 1, 32'h0,    32'h0000_0093, 0);
    add("hold_done",          0, 32'h0,    1, 0, 10'd0,    32'h0,         1, 0, 32'h0,    32'h0,         0);

    // Clock/reset
    reset_i = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) apply_row(vecs[i]);

    // Backpressure: 8 sequential requests with the consumer stalled
    for (int i = 8; i <= 16; i++) do_load(10'(i), 32'h1000_0000 + 32'(i));
    next = 0;
    for (int c = 0; c < 8; c++) begin
      a = 32'h20 + 32'(4 * next);
      step(1'b1, a, 1'b0, 1'b0, 1'b0);
      if (req_ready_o) begin
        exp_q.push_back(a);
        next++;
      end
    end
    chk("bp_accepted_while_stalled", 32'(next), 32'd4);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("bp_ready_low_when_full", 32'(req_ready_o), 32'd0);
    chk("bp_valid_when_full", 32'(rsp_valid_o), 32'd1);

    got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      a = 32'h20 + 32'(4 * next);
      step(next < 8, a, 1'b1, 1'b0, 1'b0);
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("bp_unexpected_rsp", rsp_addr_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("bp_rsp_addr", rsp_addr_o, e);
          chk("bp_rsp_instr", rsp_instr_o, model_mem[int'(e >> 2)]);
          chk("bp_rsp_fault", 32'(rsp_fault_o), 32'd0);
        end
        got++;
      end
      if (next < 8 && req_ready_o) begin
        exp_q.push_back(a);
        next++;
      end
    end
    chk("bp_total_responses", 32'(got), 32'd8);
    chk("bp_total_accepted", 32'(next), 32'd8);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Flush with four outstanding requests and a new-stream request in the flush cycle
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h20 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
    chk("flush_forces_ready", 32'(req_ready_o), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_next_cycle_empty", 32'(rsp_valid_o), 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      if (c == 0) begin
        chk("flush_rsp_valid_t2", 32'(rsp_valid_o), 32'd1);
        chk("flush_rsp_addr", rsp_addr_o, 32'h40);
        chk("flush_rsp_instr", rsp_instr_o, model_mem[16]);
      end
      if (rsp_valid_o) seen++;
    end
    chk("flush_single_response", 32'(seen), 32'd1);

    // Reset with two entries buffered
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h24, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_head", rsp_addr_o, 32'h20);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_valid", 32'(rsp_valid_o), 32'd0);
    chk("post_reset_ready", 32'(req_ready_o), 32'd1);
    chk("post_reset_addr", rsp_addr_o, 32'h0);
    step(1'b1, 32'h24, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("post_reset_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("post_reset_rsp_addr", rsp_addr_o, 32'h24);
    chk("mem_retained_after_reset", rsp_instr_o, model_mem[9]);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("post_reset_drained", 32'(rsp_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
